// File: rtl/fifo_v4.sv
// fifo_v4: synchronous valid/ready FIFO with an arbitrary depth, a fill count,
// programmable almost-full/almost-empty flags and optional fall-through.
// Optional high-water mark: define FIFO_V4_WATERMARK_EN to add clr_max_i / max_usage_o.
module fifo_v4 #(
  parameter logic        FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned ALM_FULL_TH  = DEPTH - 1,
  parameter int unsigned ALM_EMPTY_TH = 1,
  parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  testmode_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [ADDR_DEPTH:0]   usage_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  alm_full_o,
  output logic                  alm_empty_o
`ifdef FIFO_V4_WATERMARK_EN
  ,
  input  logic                  clr_max_i,
  output logic [ADDR_DEPTH:0]   max_usage_o
`endif
);

  localparam int unsigned PTR_W = ADDR_DEPTH;
  localparam int unsigned CNT_W = ADDR_DEPTH + 1;

  // Elaboration-time parameter legality
  if (DEPTH < 1 || DEPTH > 65536) begin : g_bad_depth
    $error("fifo_v4: DEPTH must be within 1..65536");
  end
  if (ADDR_DEPTH != ((DEPTH > 1) ? $clog2(DEPTH) : 1)) begin : g_bad_addr
    $error("fifo_v4: ADDR_DEPTH is derived and must not be overridden");
  end
  // DEPTH=1 with the default threshold yields 0, which is accepted as "always almost full"
  if (ALM_FULL_TH > DEPTH || (ALM_FULL_TH < 1 && DEPTH != 1)) begin : g_bad_afull
    $error("fifo_v4: ALM_FULL_TH must be within 1..DEPTH");
  end
  if (ALM_EMPTY_TH > DEPTH - 1) begin : g_bad_aempty
    $error("fifo_v4: ALM_EMPTY_TH must be within 0..DEPTH-1");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr_n;
  logic [PTR_W-1:0]      rd_ptr_n;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      usage_n;
  logic                  push;
  logic                  pop;
  logic                  bypass;
  logic                  push_w;
  logic                  pop_w;
  logic                  gate_en;

  // Status flags come from the registered count only
  always_comb begin
    full_o      = (count == CNT_W'(DEPTH));
    empty_o     = (count == '0);
    alm_full_o  = (count >= CNT_W'(ALM_FULL_TH));
    alm_empty_o = (count <= CNT_W'(ALM_EMPTY_TH));
    usage_o     = count;
  end

  // Handshake, fall-through bypass and head-data selection
  always_comb begin
    ready_o = ~full_o;
    valid_o = ~empty_o | (FALL_THROUGH & valid_i);
    push    = valid_i & ready_o;
    pop     = valid_o & ready_i;
    // Empty FIFO with push and pop together: word goes straight through, state untouched
    bypass  = FALL_THROUGH & empty_o & push & pop;
    push_w  = push & ~bypass & ~flush_i;
    pop_w   = pop & ~bypass & ~flush_i;
    gate_en = push_w | testmode_i;
    if (FALL_THROUGH && empty_o && valid_i) begin
      data_o = data_i;
    end else begin
      data_o = mem[rd_ptr];
    end
  end

  // Next pointers (wrap at DEPTH-1) and next count
  always_comb begin
    wr_ptr_n = wr_ptr;
    rd_ptr_n = rd_ptr;
    usage_n  = count;
    if (flush_i) begin
      wr_ptr_n = '0;
      rd_ptr_n = '0;
      usage_n  = '0;
    end else begin
      if (push_w) begin
        wr_ptr_n = (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop_w) begin
        rd_ptr_n = (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      if (push_w && !pop_w) begin
        usage_n = count + CNT_W'(1);
      end else if (pop_w && !push_w) begin
        usage_n = count - CNT_W'(1);
      end
    end
  end

  // Pointer and count registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      count  <= usage_n;
    end
  end

  // Storage: an entry changes only on a push to its address; flush leaves contents alone
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (gate_en) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (push_w && wr_ptr == PTR_W'(i)) begin
          mem[i] <= data_i;
        end
      end
    end
  end

`ifdef FIFO_V4_WATERMARK_EN
  // High-water mark of the fill count
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      max_usage_o <= '0;
    end else if (flush_i) begin
      max_usage_o <= '0;
    end else if (clr_max_i) begin
      max_usage_o <= push_w ? usage_n : '0;
    end else if (usage_n > max_usage_o) begin
      max_usage_o <= usage_n;
    end
  end
`else
  // No high-water mark in this build
`endif

`ifndef SYNTHESIS
  // Producer must hold valid_i and data_i while backpressured
  a_hold_while_full : assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
    (valid_i && !ready_o) |=> (valid_i && $stable(data_i)))
    else $error("fifo_v4: producer dropped or changed data while ready_o was low");

  // Fill count is bounded by the depth
  a_count_bound : assert property (@(posedge clk_i) disable iff (rst_i)
    count <= CNT_W'(DEPTH))
    else $error("fifo_v4: count exceeds DEPTH");
`endif

endmodule
